seven_seg_scanner: RTL and testbench
====================================

Name: seven_seg_scanner

Overview:
Time-multiplexing driver that feeds the 8-digit seven_segment_display decoder. It supplies the decoder's num and sel inputs. It holds a 32-bit display word, steps sel through digits 0..7 at a programmable refresh rate, and presents the matching nibble on num. New display words are accepted through a valid/ready handshake and are applied only at a frame boundary, so a partially updated word is never shown.

Parameters:
DIGIT_CYCLES, 100000, clock cycles each digit stays selected; legal range 2..2^24.
CNT_W, $clog2(DIGIT_CYCLES), width of the refresh counter.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
load_data  in  32  display word; nibble k = load_data[4k+3:4k] is shown on digit k
load_valid  in  1  load_data is valid this cycle
load_ready  out  1  scanner can accept a word; transfer occurs when load_valid & load_ready at a rising clk edge
digit_en  in  8  per-digit enable; 0 = blank that digit
num  out  4  nibble for the current digit; drives decoder num
sel  out  3  current digit index; drives decoder sel
blank  out  1  current digit disabled; gates anode outside this block
frame_start  out  1  one-cycle pulse in the first cycle of each frame (sel becomes 0)

Behaviour:
- Registers: tick (CNT_W), sel (3), shown (32), pending (32), pend_flag (1), num (4), frame_start (1).
- Reset (rst_n low, asynchronous): tick=0, sel=0, shown=0, pending=0, pend_flag=0, num=0, frame_start=0. load_ready=1 once reset is released. blank = ~digit_en[0].
- Refresh: tick increments each cycle. When tick==DIGIT_CYCLES-1, tick wraps to 0 and sel increments modulo 8 (7->0). Each digit is held for exactly DIGIT_CYCLES cycles, and a frame lasts 8*DIGIT_CYCLES cycles.
- frame_start is registered. It is 1 in exactly the cycle in which sel first reads 0 after a 7->0 wrap, and 0 in all other cycles. It is not asserted coming out of reset.
- Handshake: load_ready = ~pend_flag (combinational from the register). On an accepted transfer, pending<=load_data and pend_flag<=1. While load_ready is 0, load_valid is ignored and load_data is not sampled.
- Frame-boundary commit: on the edge where sel wraps 7->0 and pend_flag=1, shown<=pending and pend_flag<=0. From the first cycle of the new frame, the new word is visible and load_ready is 1.
- Commit and accept in the same cycle cannot happen, because accept requires pend_flag=0 and commit requires pend_flag=1. A word offered on the commit edge is accepted on the next edge at the earliest.
- num is registered and always equals shown[4*sel+3 : 4*sel] for the current sel and shown. It updates on the same edge as sel or shown, so num and sel never disagree in any cycle.
- blank = ~digit_en[sel] (combinational). num and sel keep scanning when blank=1.
- At most one word is buffered. A producer holding load_valid high stalls until the next frame boundary; no data is lost or overwritten.
- Reset asserted mid-frame discards pending and shown, and scanning restarts at sel=0, tick=0.

Test Plan:
(All tests use DIGIT_CYCLES=4.)
1. Reset check: assert rst_n=0 with digit_en=8'hFF, then release -> sel=0, num=0, blank=0, load_ready=1, frame_start=0.
2. Scan timing: after reset, no loads -> sel steps 0,1,...,7,0 every 4 cycles; the 7->0 wrap occurs 32 cycles after reset release; frame_start=1 for exactly that one cycle.
3. Load and commit: in frame 0, send load_data=32'h89ABCDEF (one valid cycle) -> load_ready=0 the next cycle; num stays 0 until the wrap; in the next frame num reads F,E,D,C,B,A,9,8 for sel 0..7; load_ready returns to 1 on the first cycle of that frame.
4. Back-pressure: after 32'h11111111 is accepted, hold load_valid=1 with 32'h22222222 -> not accepted until load_ready=1 at the boundary; then a frame of 1s followed by a frame of 2s; no frame mixes nibbles from both words.
5. Blanking: digit_en=8'h0F -> blank=1 exactly while sel is in 4..7; num still tracks shown; toggling digit_en mid-digit changes blank in the same cycle.
6. Reset mid-operation: a word is pending and sel=5 when rst_n is pulsed low -> shown=0, load_ready=1, sel=0, tick=0 immediately; the pending word is never displayed.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexing driver for an 8-digit seven-segment decoder.
// Holds a 32-bit display word, steps sel through digits 0..7 with each digit held
// for DIGIT_CYCLES clocks, and presents the matching nibble on num. New words are
// accepted over a valid/ready handshake into a one-deep buffer. They become visible
// only at a frame boundary, so a frame never mixes two words.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   load_data    display word; nibble k is shown on digit k
//   load_valid   load_data is valid this cycle
//   load_ready   buffer is empty and a word can be accepted
//   digit_en     per-digit enable; 0 blanks that digit
//   num          nibble for the current digit
//   sel          current digit index
//   blank        current digit is disabled
//   frame_start  one-cycle pulse in the first cycle of each frame
module seven_seg_scanner #(
  parameter int unsigned DIGIT_CYCLES = 100000,
  parameter int unsigned CNT_W        = $clog2(DIGIT_CYCLES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] load_data,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [7:0]  digit_en,
  output logic [3:0]  num,
  output logic [2:0]  sel,
  output logic        blank,
  output logic        frame_start
);

  localparam logic [CNT_W-1:0] TickMax = CNT_W'(DIGIT_CYCLES - 1);

  logic [CNT_W-1:0] tick_q, tick_d;
  logic [2:0]       sel_q, sel_d;
  logic [31:0]      shown_q, shown_d;
  logic [31:0]      pending_q, pending_d;
  logic             pend_flag_q, pend_flag_d;
  logic [3:0]       num_q, num_d;
  logic             frame_start_q, frame_start_d;

  logic tick_wrap;
  logic frame_wrap;
  logic accept;
  logic commit;

  always_comb begin
    tick_wrap  = (tick_q == TickMax);
    frame_wrap = tick_wrap && (sel_q == 3'd7);
    // accept needs an empty buffer and commit a full one, so they never coincide
    accept     = load_valid && !pend_flag_q;
    commit     = frame_wrap && pend_flag_q;

    tick_d        = tick_wrap ? '0 : tick_q + CNT_W'(1);
    sel_d         = tick_wrap ? sel_q + 3'd1 : sel_q;
    frame_start_d = frame_wrap;

    shown_d     = shown_q;
    pending_d   = pending_q;
    pend_flag_d = pend_flag_q;
    if (commit) begin
      shown_d     = pending_q;
      pend_flag_d = 1'b0;
    end
    if (accept) begin
      pending_d   = load_data;
      pend_flag_d = 1'b1;
    end

    // Derived from next-state values so num always matches sel and shown.
    num_d = shown_d[{sel_d, 2'b00} +: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q        <= '0;
      sel_q         <= 3'd0;
      shown_q       <= 32'd0;
      pending_q     <= 32'd0;
      pend_flag_q   <= 1'b0;
      num_q         <= 4'd0;
      frame_start_q <= 1'b0;
    end else begin
      tick_q        <= tick_d;
      sel_q         <= sel_d;
      shown_q       <= shown_d;
      pending_q     <= pending_d;
      pend_flag_q   <= pend_flag_d;
      num_q         <= num_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign load_ready  = ~pend_flag_q;
  assign num         = num_q;
  assign sel         = sel_q;
  assign blank       = ~digit_en[sel_q];
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner with DIGIT_CYCLES=4. The reference model tracks the
// number of clock edges since reset release plus a one-entry queue of pending words.
// Expected outputs are derived arithmetically from those.
module tb_seven_seg_scanner;

  localparam int unsigned DC    = 4;
  localparam int unsigned Frame = 8 * DC;

  logic        clk;
  logic        rst_n;
  logic [31:0] load_data;
  logic        load_valid;
  logic        load_ready;
  logic [7:0]  digit_en;
  logic [3:0]  num;
  logic [2:0]  sel;
  logic        blank;
  logic        frame_start;

  seven_seg_scanner #(
    .DIGIT_CYCLES(DC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .digit_en   (digit_en),
    .num        (num),
    .sel        (sel),
    .blank      (blank),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int unsigned m_cyc;
  logic [31:0] m_shown;
  logic [31:0] m_q[$];

  int unsigned n_vec;
  int unsigned n_miss;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned m_sel();
    return (m_cyc / DC) % 8;
  endfunction

  task automatic check_all();
    int unsigned s;
    logic [7:0] en;
    s  = m_sel();
    en = digit_en;
    check_eq("sel", {29'd0, sel}, s);
    check_eq("num", {28'd0, num}, (m_shown >> (4 * s)) & 32'hF);
    check_eq("blank", {31'd0, blank}, {31'd0, ~en[s]});
    check_eq("load_ready", {31'd0, load_ready}, {31'd0, (m_q.size() == 0)});
    check_eq("frame_start", {31'd0, frame_start},
             {31'd0, (m_cyc > 0 && (m_cyc % Frame) == 0)});
  endtask

  // Called at a negedge: drive, check, take one rising edge, update model, back to negedge.
  task automatic step(input logic v, input logic [31:0] d, input logic [7:0] en,
                      output bit acc);
    load_valid = v;
    load_data  = d;
    digit_en   = en;
    #1;
    check_all();
    acc = v && (m_q.size() == 0);
    @(posedge clk);
    m_cyc++;
    if ((m_cyc % Frame) == 0 && m_q.size() > 0) m_shown = m_q.pop_front();
    if (acc) m_q.push_back(d);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [7:0] en);
    load_valid = 1'b0;
    digit_en   = en;
    rst_n      = 1'b0;
    m_cyc      = 0;
    m_shown    = 32'd0;
    m_q.delete();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit          acc;
    bit          hold_v;
    logic [31:0] hold_d;
    logic [7:0]  en;
    bit          hit;
    n_vec      = 0;
    n_miss     = 0;
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = 32'd0;
    digit_en   = 8'hFF;
    m_cyc      = 0;
    m_shown    = 32'd0;
    @(negedge clk);
    do_reset(8'hFF);

    // Idle scan, then one word offered for a single cycle in frame 0.
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 8'hFF, acc);
    step(1'b1, 32'h89ABCDEF, 8'hFF, acc);
    for (int i = 0; i < 70; i++) step(1'b0, 32'hDEADBEEF, 8'hFF, acc);

    // Back-pressure: 1s accepted, then 2s held until the boundary frees the buffer.
    acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) step(1'b1, 32'h11111111, 8'hFF, acc);
    check_eq("accept_1s", {31'd0, acc}, 32'd1);
    acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) step(1'b1, 32'h22222222, 8'hFF, acc);
    check_eq("accept_2s", {31'd0, acc}, 32'd1);
    for (int i = 0; i < 70; i++) step(1'b0, 32'd0, 8'h0F, acc);

    // Randomized producer with stable-while-stalled data and changing digit enables.
    hold_v = 1'b0;
    hold_d = 32'd0;
    en     = 8'hFF;
    for (int i = 0; i < 800; i++) begin
      if (!hold_v && ($urandom % 4) == 0) begin
        hold_v = 1'b1;
        hold_d = $urandom;
      end
      if (($urandom % 3) == 0) en = 8'($urandom);
      step(hold_v, hold_d, en, acc);
      if (acc) hold_v = 1'b0;
    end

    // Reset while a word is pending and digit 5 is selected.
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (m_q.size() > 0 && m_sel() == 5) hit = 1'b1;
      else step(1'b1, 32'hCAFEF00D, 8'hFF, acc);
    end
    check_eq("reach_pending_sel5", {31'd0, hit}, 32'd1);
    do_reset(8'hF0);
    for (int i = 0; i < 80; i++) step(1'b0, 32'd0, 8'hF0, acc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
